hex_share_arbiter: RTL and testbench

- Round-robin arbiter and display sequencer for the shared two-digit hex display pair (HEX5/HEX4).
- Two requesters submit an 8-bit value with a req/ack handshake.
- The granted value is latched and shown for a fixed dwell time, then the display passes to the other requester or goes idle.
- Outputs are nibbles for the existing 7-segment decoders; this block contains no segment logic.

---
 rtl/hex_share_arbiter.sv | 136 +++++++++++++
 tb/tb_hex_share_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_share_arbiter.sv
// Round-robin arbiter and dwell sequencer for the shared HEX5/HEX4 display pair.
// Optional HEX_SHARE_BLANK_IDLE_EN blanks the digits while idle.
module hex_share_arbiter #(
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned CW    = $clog2(DWELL)
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic [3:0] hex_hi,
  output logic [3:0] hex_lo,
  output logic       hex_blank,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShowA, StShowB} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;  // 1 = B served most recently
  logic [1:0]    grant_q, grant_d;
  logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic          busy_q, busy_d;
  logic [3:0]    hi_q, hi_d, lo_q, lo_d;
  logic          arb, win_a, win_b;

`ifdef HEX_SHARE_BLANK_IDLE_EN
  logic blank_q, blank_d;
  assign hex_blank = blank_q;
`else
  assign hex_blank = 1'b0;
`endif

  assign arb   = (state_q == StIdle) || (cnt_q == '0);
  // Tie goes to whoever was not served last.
  assign win_a = req_a && (!req_b || last_q);
  assign win_b = req_b && !win_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef HEX_SHARE_BLANK_IDLE_EN
    blank_d = blank_q;
`endif
    if (arb) begin
      if (win_a) begin
        state_d = StShowA;
        cnt_d   = CW'(DWELL - 1);
        last_d  = 1'b0;
        grant_d = 2'b01;
        ack_a_d = 1'b1;
        busy_d  = 1'b1;
        hi_d    = data_a[7:4];
        lo_d    = data_a[3:0];
`ifdef HEX_SHARE_BLANK_IDLE_EN
        blank_d = 1'b0;
`endif
      end else if (win_b) begin
        state_d = StShowB;
        cnt_d   = CW'(DWELL - 1);
        last_d  = 1'b1;
        grant_d = 2'b10;
        ack_b_d = 1'b1;
        busy_d  = 1'b1;
        hi_d    = data_b[7:4];
        lo_d    = data_b[3:0];
`ifdef HEX_SHARE_BLANK_IDLE_EN
        blank_d = 1'b0;
`endif
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
        grant_d = 2'b00;
        busy_d  = 1'b0;
`ifdef HEX_SHARE_BLANK_IDLE_EN
        hi_d    = 4'h0;
        lo_d    = 4'h0;
        blank_d = 1'b1;
`endif
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 4'h0;
      lo_q    <= 4'h0;
`ifdef HEX_SHARE_BLANK_IDLE_EN
      blank_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef HEX_SHARE_BLANK_IDLE_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign ack_a  = ack_a_q;
  assign ack_b  = ack_b_q;
  assign grant  = grant_q;
  assign busy   = busy_q;
  assign hex_hi = hi_q;
  assign hex_lo = lo_q;

endmodule

// File: tb/tb_hex_share_arbiter.sv
// Randomized and directed bench for hex_share_arbiter against a grant-level reference model.
module tb_hex_share_arbiter;

  localparam int unsigned DWELL = 4;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, hex_blank, busy;
  logic [3:0] hex_hi, hex_lo;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

`ifdef HEX_SHARE_BLANK_IDLE_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  // Reference model: who owns the display, how many dwell cycles remain, who went last.
  int         m_owner;  // 0 none, 1 A, 2 B
  int         m_left;
  int         m_last;
  logic [7:0] m_disp;
  logic       m_ack_a, m_ack_b;

  hex_share_arbiter #(.DWELL(DWELL)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .req_a    (req_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .hex_hi   (hex_hi),
    .hex_lo   (hex_lo),
    .hex_blank(hex_blank),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_left  = 0;
    m_last  = 2;
    m_disp  = 8'h00;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
  endtask

  task automatic model_edge();
    int pick;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    if (m_owner == 0 || m_left == 1) begin
      if (req_a && req_b) pick = (m_last == 1) ? 2 : 1;
      else if (req_a)     pick = 1;
      else if (req_b)     pick = 2;
      else                pick = 0;
      m_owner = pick;
      if (pick != 0) begin
        m_left = DWELL;
        m_last = pick;
        m_disp = (pick == 1) ? data_a : data_b;
        if (pick == 1) m_ack_a = 1'b1;
        else           m_ack_b = 1'b1;
      end else begin
        m_left = 0;
        if (BlankEn) m_disp = 8'h00;
      end
    end else begin
      m_left--;
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    check("grant", grant, eg);
    check("busy", busy, m_owner != 0);
    check("ack_a", ack_a, m_ack_a);
    check("ack_b", ack_b, m_ack_b);
    check("hex", {hex_hi, hex_lo}, m_disp);
    check("hex_blank", hex_blank, BlankEn && (m_owner == 0));
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    if (KEY0) model_edge();
    cyc++;
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic idle_run(input int n);
    req_a = 1'b0;
    req_b = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset away from a clock edge and check the asynchronous response.
  task automatic pulse_reset();
    KEY0 = 1'b0;
    #1;
    model_reset();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_hex", {hex_hi, hex_lo}, 8'h00);
    check("rst_ack", {ack_a, ack_b}, 2'b00);
    check("rst_blank", hex_blank, BlankEn);
    cycle();
    KEY0 = 1'b1;
  endtask

  initial begin
    int ca, cb, prev, win;
    KEY0 = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    model_reset();
    @(negedge CLOCK_50);
    pulse_reset();

    // Single request
    req_a = 1'b1; data_a = 8'h3C;
    cycle();
    check("s1_ack_a", ack_a, 1'b1);
    check("s1_grant", grant, 2'b01);
    check("s1_hex", {hex_hi, hex_lo}, 8'h3C);
    req_a = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("s1_hold", grant, 2'b01);
    cycle();
    check("s1_end_grant", grant, 2'b00);
    check("s1_end_busy", busy, 1'b0);
    idle_run(2);

    // Tie after reset: A first, B follows with no gap
    pulse_reset();
    req_a = 1'b1; data_a = 8'h12; req_b = 1'b1; data_b = 8'hAB;
    cycle();
    check("s2_a_first", ack_a, 1'b1);
    ca = cyc; cb = 0;
    req_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (ack_b) begin cb = cyc; break; end
    end
    req_b = 1'b0;
    check("s2_gap", cb - ca, DWELL);
    check("s2_hex_b", {hex_hi, hex_lo}, 8'hAB);

    // Reset during the 3rd SHOW_B cycle, then both request: A wins
    cycle(); cycle();
    check("s5_in_b", grant, 2'b10);
    req_a = 1'b1; data_a = 8'h55; req_b = 1'b1; data_b = 8'h66;
    pulse_reset();
    cycle();
    check("s5_a_wins", ack_a, 1'b1);

    // Data change after ack must not disturb the display
    req_a = 1'b0; req_b = 1'b0; data_a = 8'h99;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("s4_stable", {hex_hi, hex_lo}, 8'h55);
    end
    idle_run(3);

    // Fairness: both held, strict alternation
    req_a = 1'b1; data_a = 8'h0F; req_b = 1'b1; data_b = 8'hF0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ack_a || ack_b) begin
        win = ack_a ? 1 : 2;
        if (prev != 0) check("s3_alternate", win != prev, 1'b1);
        prev = win;
      end
    end
    idle_run(6);

    // Idle display after a single 0x7E grant
    req_a = 1'b1; data_a = 8'h7E;
    cycle();
    req_a = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("s6_grant", grant, 2'b00);
`ifdef HEX_SHARE_BLANK_IDLE_EN
    check("s6_blank", hex_blank, 1'b1);
    check("s6_hex", {hex_hi, hex_lo}, 8'h00);
`else
    check("s6_blank", hex_blank, 1'b0);
    check("s6_hex", {hex_hi, hex_lo}, 8'h7E);
`endif

    // Randomized traffic obeying the requester handshake rules
    for (int i = 0; i < 3000; i++) begin
      if (m_ack_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 3) == 0) begin
        req_a = 1'b1; data_a = 8'($urandom);
      end
      if (m_ack_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 3) == 0) begin
        req_b = 1'b1; data_b = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
